// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the single-ported main memory between instruction fetch (I)
//   and data load/store (D). It grants one requester at a time and drives the
//   memory enable/RW/byte strobes. It completes the access on MOC, or aborts
//   it after TIMEOUT enable cycles. It returns read data and a one-cycle ack
//   to the winner.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-low reset
//   i_req/i_addr       fetch request (always a word read)
//   i_ack/i_rdata      fetch completion pulse / fetched word (held)
//   d_req/d_rw/d_byte  data request, 1=write, 1=byte access
//   d_addr/d_wdata     data address / store data
//   d_ack/d_rdata      data completion pulse / load data (held)
//   mem_*              memory-side strobes, address, data, MOC handshake
//   busy               high while the sequencer is not idle
//   timeout_err        pulses together with the ack of a timed-out access
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic          d_byte,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_enable,
    output logic          mem_rw,
    output logic          mem_byte,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_moc,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] starv;   // D grants made while I was waiting; saturates at 2
    logic [7:0] wcnt;    // cycles spent in ACCESS
    logic       owner;   // 1 = D owns the current access, 0 = I

    // The mem_* output registers double as the latched request. They are
    // loaded only on a grant, so they stay stable for the whole access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            starv       <= '0;
            wcnt        <= '0;
            owner       <= 1'b0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b0;
            mem_byte    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // D has priority unless I has already lost twice in a row.
                    if (d_req && !(starv == 2'd2 && i_req)) begin
                        owner      <= 1'b1;
                        mem_addr   <= d_addr;
                        mem_rw     <= d_rw;
                        mem_byte   <= d_byte;
                        mem_wdata  <= d_wdata;
                        mem_enable <= 1'b1;
                        busy       <= 1'b1;
                        wcnt       <= '0;
                        state      <= ACCESS;
                        if (i_req && starv != 2'd2)
                            starv <= starv + 2'd1;
                    end else if (i_req) begin
                        owner      <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_rw     <= 1'b0;
                        mem_byte   <= 1'b0;
                        mem_wdata  <= '0;
                        mem_enable <= 1'b1;
                        busy       <= 1'b1;
                        wcnt       <= '0;
                        starv      <= '0;
                        state      <= ACCESS;
                    end
                end

                ACCESS: begin
                    wcnt <= wcnt + 8'd1;
                    if (mem_moc) begin
                        mem_enable <= 1'b0;
                        state      <= RELEASE;
                        if (owner) begin
                            d_ack <= 1'b1;
                            if (!mem_rw)
                                d_rdata <= mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (wcnt == WAIT_LAST) begin
                        // No MOC in time. Complete the access anyway so the
                        // requester never hangs, and zero any read result.
                        mem_enable  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                        if (owner) begin
                            d_ack <= 1'b1;
                            if (!mem_rw)
                                d_rdata <= '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end
                end

                RELEASE: begin
                    // An extra idle cycle guarantees two enable-low cycles
                    // between accesses.
                    i_ack       <= 1'b0;
                    d_ack       <= 1'b0;
                    timeout_err <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Requester tasks issue accesses and push the expected completion into
//   per-requester queues. A memory model answers from the address. A monitor
//   pops and compares on every ack.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk, reset;
    logic        i_req, i_ack, d_req, d_rw, d_byte, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_enable, mem_rw, mem_byte, mem_moc, busy, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_moc(mem_moc),
        .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rw;
        logic        byt;
        logic        tmo;
        int          en;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [7:0]  order[$];
    logic [31:0] exp_i, exp_d;   // model of the held rdata registers
    int          vectors = 0;
    int          miscompares = 0;

    // Memory behaviour is a pure function of the address.
    function automatic int mem_lat(input logic [31:0] a);
        if (a == 32'h10) return 3;
        case (a[7:4])
            4'hF:    return 20;
            4'hE:    return 15;
            4'hD:    return 16;
            default: return int'(a[1:0]) + 1;
        endcase
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: MOC rises on the mem_lat-th enabled cycle.
    initial begin
        int mcnt;
        mcnt = 0;
        mem_moc = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_enable === 1'b1) begin
                mcnt++;
                mem_moc   = (mcnt >= mem_lat(mem_addr));
                mem_rdata = mem_data(mem_addr);
            end else begin
                mcnt      = 0;
                mem_moc   = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: captures the bus during enable and scores each ack.
    initial begin
        int          en_cnt, dwhile;
        logic        unstable, cap_rw, cap_byte;
        logic [31:0] cap_addr, cap_wdata;
        exp_t        e;
        en_cnt = 0; dwhile = 0; unstable = 0;
        cap_rw = 0; cap_byte = 0; cap_addr = 0; cap_wdata = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                en_cnt = 0; unstable = 0; dwhile = 0;
            end else begin
                if (mem_enable === 1'b1) begin
                    if (en_cnt == 0) begin
                        cap_addr = mem_addr; cap_wdata = mem_wdata;
                        cap_rw = mem_rw; cap_byte = mem_byte; unstable = 0;
                    end else if (cap_addr !== mem_addr || cap_wdata !== mem_wdata ||
                                 cap_rw !== mem_rw || cap_byte !== mem_byte) begin
                        unstable = 1;
                    end
                    en_cnt++;
                end
                if (i_ack === 1'b1 && d_ack === 1'b1)
                    chk("dual_ack", 32'd1, 32'd0);
                if (d_ack === 1'b1 && i_req === 1'b1)
                    dwhile++;
                if (i_ack === 1'b1) begin
                    order.push_back("I");
                    if (iq.size() == 0) begin
                        chk("unexpected_i_ack", 32'd1, 32'd0);
                    end else begin
                        e = iq.pop_front();
                        chk("i_addr", cap_addr, e.addr);
                        chk("i_rw_byte", {cap_rw, cap_byte}, 32'd0);
                        chk("i_rdata", i_rdata, e.rdata);
                        chk("i_timeout", timeout_err, e.tmo);
                        chk("i_en_cycles", en_cnt, e.en);
                        chk("i_stable", unstable, 32'd0);
                        chk("i_busy", busy, 32'd1);
                        chk("i_starve", (dwhile <= 3), 32'd1);
                    end
                    dwhile = 0;
                end
                if (d_ack === 1'b1) begin
                    order.push_back("D");
                    if (dq.size() == 0) begin
                        chk("unexpected_d_ack", 32'd1, 32'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("d_addr", cap_addr, e.addr);
                        chk("d_rw_byte", {cap_rw, cap_byte}, {e.rw, e.byt});
                        if (e.rw) chk("d_wdata", cap_wdata, e.wdata);
                        chk("d_rdata", d_rdata, e.rdata);
                        chk("d_timeout", timeout_err, e.tmo);
                        chk("d_en_cycles", en_cnt, e.en);
                        chk("d_stable", unstable, 32'd0);
                    end
                end
                if (timeout_err === 1'b1 && i_ack !== 1'b1 && d_ack !== 1'b1)
                    chk("stray_timeout", 32'd1, 32'd0);
                if (mem_enable !== 1'b1 && i_ack !== 1'b1 && d_ack !== 1'b1) begin
                    en_cnt = 0;
                    unstable = 0;
                end
            end
        end
    end

    task automatic do_i(input logic [31:0] a);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        i_addr = a;
        i_req  = 1'b1;
        lat    = mem_lat(a);
        e.addr = a; e.wdata = '0; e.rw = 1'b0; e.byt = 1'b0;
        e.tmo  = (lat > TIMEOUT);
        e.en   = e.tmo ? TIMEOUT : lat;
        exp_i  = e.tmo ? 32'd0 : mem_data(a);
        e.rdata = exp_i;
        iq.push_back(e);
        got = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (i_ack === 1'b1) begin got = 1; break; end
        end
        i_req = 1'b0;
        if (!got) chk("i_ack_wait", 32'd0, 32'd1);
    endtask

    task automatic do_d(input logic rw, input logic byt, input logic [31:0] a,
                        input logic [31:0] wd);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        d_rw = rw; d_byte = byt; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        lat   = mem_lat(a);
        e.addr = a; e.wdata = wd; e.rw = rw; e.byt = byt;
        e.tmo  = (lat > TIMEOUT);
        e.en   = e.tmo ? TIMEOUT : lat;
        if (!rw) exp_d = e.tmo ? 32'd0 : mem_data(a);
        e.rdata = exp_d;
        dq.push_back(e);
        got = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (d_ack === 1'b1) begin got = 1; break; end
        end
        d_req = 1'b0;
        if (!got) chk("d_ack_wait", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ctl"}, {mem_enable, mem_rw, mem_byte, busy, i_ack, d_ack, timeout_err}, 32'd0);
        chk({nm, "_addr"}, mem_addr, 32'd0);
        chk({nm, "_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    initial begin
        string exp_order;
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_rw = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
        exp_i = '0; exp_d = '0;

        // Reset held with both requests pending; D must win after release.
        @(negedge clk);
        order.delete();
        fork
            do_i(32'h0000_0104);
            do_d(1'b0, 1'b0, 32'h0000_0208, 32'h0);
        join_none
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("reset");
        end
        reset = 1'b1;
        wait fork;
        exp_order = "DI";
        for (int k = 0; k < 2; k++)
            chk("reset_grant_order", (k < order.size()) ? order[k] : 8'h0, exp_order[k]);

        // Directed accesses: fetch, byte store, timeout, latency boundaries.
        do_i(32'h0000_0010);
        do_d(1'b1, 1'b1, 32'h0000_0023, 32'h0000_00AB);
        do_d(1'b0, 1'b0, 32'h0000_00F0, 32'h0);
        do_d(1'b0, 1'b0, 32'h0000_00E4, 32'h0);
        do_i(32'h0000_00D8);
        do_i(32'h0000_00E1);

        // Contention: both requesters re-assert immediately after every ack.
        order.delete();
        fork
            begin
                repeat (4) do_d(1'(($urandom) & 1), 1'(($urandom) & 1),
                                $urandom & 32'hFFFF_FF0F, $urandom);
            end
            begin
                repeat (2) do_i($urandom & 32'hFFFF_FF0F);
            end
        join
        exp_order = "DDIDDI";
        for (int k = 0; k < 6; k++)
            chk("contention_order", (k < order.size()) ? order[k] : 8'h0, exp_order[k]);

        // Reset in the middle of a long access: abandoned, no ack.
        @(negedge clk);
        d_rw = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_00F8; d_req = 1'b1;
        @(negedge clk);
        chk("midreset_enable_on", mem_enable, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        d_req = 1'b0;
        exp_i = '0; exp_d = '0;
        @(negedge clk);
        chk("midreset_enable_off", {mem_enable, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midreset_no_ack", {i_ack, d_ack, mem_enable}, 32'd0);
        end
        do_d(1'b0, 1'b0, 32'h0000_0302, 32'h0);
        do_i(32'h0000_0401);

        // Randomized traffic from both requesters.
        fork
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_i($urandom);
                end
            end
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_d(1'(($urandom) & 1), 1'(($urandom) & 1), $urandom, $urandom);
                end
            end
        join

        repeat (5) @(negedge clk);
        chk("pending_expectations", iq.size() + dq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
